// File: rtl/match_controller.sv
// Match sequencing for a paddle game: serve delay, point scoring, win detection and start/pause.
// Optional pause support is enabled by defining MATCH_CTRL_PAUSE_EN.
module match_controller #(
   parameter int unsigned X_POS_W       = 10,
   parameter int unsigned SCORE_W       = 4,
   parameter int unsigned WIN_SCORE     = 7,
   parameter int unsigned SERVE_FRAMES  = 60,
   parameter int unsigned SCREEN_H_RES  = 640,
   parameter int unsigned SCREEN_BORDER = 10
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               new_frame_i,
   input  logic               start_key_i,
   input  logic [X_POS_W-1:0] ball_x_i,
   output logic               run_o,
   output logic               ball_reset_o,
   output logic [SCORE_W-1:0] player_score_o,
   output logic [SCORE_W-1:0] enemy_score_o,
   output logic [2:0]         state_o,
   output logic               winner_o
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StServe    = 3'd1;
   localparam logic [2:0] StPlay     = 3'd2;
   localparam logic [2:0] StPoint    = 3'd3;
   localparam logic [2:0] StGameOver = 3'd4;
`ifdef MATCH_CTRL_PAUSE_EN
   localparam logic [2:0] StPaused   = 3'd5;
`endif

   localparam int unsigned        CntW      = $clog2(SERVE_FRAMES + 1);
   localparam logic [CntW-1:0]    CntLast   = CntW'(SERVE_FRAMES - 1);
   localparam logic [SCORE_W-1:0] ScoreMax  = '1;
   localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
   localparam logic [X_POS_W-1:0] RightLim  = X_POS_W'(SCREEN_H_RES);
   localparam logic [X_POS_W-1:0] LeftLim   = X_POS_W'(SCREEN_BORDER);

   logic [2:0]         state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [SCORE_W-1:0] player_q, player_d;
   logic [SCORE_W-1:0] enemy_q, enemy_d;
   logic               winner_q, winner_d;
   logic               run_q, run_d;
   logic               ball_reset_q, ball_reset_d;
   logic               pt_player_q, pt_player_d;
   logic               start_q;
   // Blocks the first cycle after reset so a held key cannot look like a fresh press.
   logic               armed_q;
   logic               start_press;

   assign start_press = start_key_i & ~start_q & armed_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      player_d     = player_q;
      enemy_d      = enemy_q;
      winner_d     = winner_q;
      pt_player_d  = pt_player_q;
      ball_reset_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_press) begin
               player_d     = '0;
               enemy_d      = '0;
               winner_d     = 1'b0;
               cnt_d        = '0;
               ball_reset_d = 1'b1;
               state_d      = StServe;
            end
         end
         StServe: begin
            if (new_frame_i) begin
               if (cnt_q == CntLast) begin
                  cnt_d   = '0;
                  state_d = StPlay;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StPlay: begin
            // A scoring frame wins over a simultaneous start press.
            if (new_frame_i && (ball_x_i > RightLim)) begin
               enemy_d      = (enemy_q == ScoreMax) ? enemy_q : enemy_q + 1'b1;
               pt_player_d  = 1'b0;
               ball_reset_d = 1'b1;
               state_d      = StPoint;
            end else if (new_frame_i && (ball_x_i < LeftLim)) begin
               player_d     = (player_q == ScoreMax) ? player_q : player_q + 1'b1;
               pt_player_d  = 1'b1;
               ball_reset_d = 1'b1;
               state_d      = StPoint;
`ifdef MATCH_CTRL_PAUSE_EN
            end else if (start_press) begin
               state_d = StPaused;
`endif
            end
         end
         StPoint: begin
            if (pt_player_q ? (player_q == WinScore) : (enemy_q == WinScore)) begin
               winner_d = pt_player_q;
               state_d  = StGameOver;
            end else begin
               state_d = StServe;
            end
         end
         StGameOver: begin
            if (start_press) state_d = StIdle;
         end
`ifdef MATCH_CTRL_PAUSE_EN
         StPaused: begin
            if (start_press) state_d = StPlay;
         end
`endif
         default: state_d = StIdle;
      endcase
      run_d = (state_d == StPlay);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         player_q     <= '0;
         enemy_q      <= '0;
         winner_q     <= 1'b0;
         pt_player_q  <= 1'b0;
         run_q        <= 1'b0;
         ball_reset_q <= 1'b0;
         start_q      <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         player_q     <= player_d;
         enemy_q      <= enemy_d;
         winner_q     <= winner_d;
         pt_player_q  <= pt_player_d;
         run_q        <= run_d;
         ball_reset_q <= ball_reset_d;
         start_q      <= start_key_i;
         armed_q      <= 1'b1;
      end
   end

   assign run_o          = run_q;
   assign ball_reset_o   = ball_reset_q;
   assign player_score_o = player_q;
   assign enemy_score_o  = enemy_q;
   assign state_o        = state_q;
   assign winner_o       = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed vector table, hand sequences and a randomized run
// checked cycle by cycle against a behavioural match model.
module tb_match_controller;

   localparam int WinScore    = 7;
   localparam int ServeFrames = 60;
   localparam int RightLim    = 640;
   localparam int LeftLim     = 10;
   localparam int ScoreMax    = 15;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       new_frame_i = 1'b0;
   logic       start_key_i = 1'b0;
   logic [9:0] ball_x_i = 10'd300;
   logic       run_o;
   logic       ball_reset_o;
   logic [3:0] player_score_o;
   logic [3:0] enemy_score_o;
   logic [2:0] state_o;
   logic       winner_o;

   int errors = 0;
   int checks = 0;

   match_controller dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .new_frame_i    (new_frame_i),
      .start_key_i    (start_key_i),
      .ball_x_i       (ball_x_i),
      .run_o          (run_o),
      .ball_reset_o   (ball_reset_o),
      .player_score_o (player_score_o),
      .enemy_score_o  (enemy_score_o),
      .state_o        (state_o),
      .winner_o       (winner_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural model: match phase plus bookkeeping, stepped once per rising edge.
   int m_phase, m_frames, m_ps, m_es, m_win, m_last_player, m_br;
   bit m_prev_key, m_armed;

   task automatic model_reset();
      m_phase = 0; m_frames = 0; m_ps = 0; m_es = 0; m_win = 0;
      m_last_player = 0; m_br = 0; m_prev_key = 0; m_armed = 0;
   endtask

   task automatic model_step(input bit key, input bit nf, input int x);
      bit press;
      press = key && !m_prev_key && m_armed;
      m_br = 0;
      case (m_phase)
         0: if (press) begin
            m_ps = 0; m_es = 0; m_frames = 0; m_br = 1; m_phase = 1;
         end
         1: if (nf) begin
            m_frames++;
            if (m_frames == ServeFrames) begin m_frames = 0; m_phase = 2; end
         end
         2: begin
            if (nf && x > RightLim) begin
               if (m_es < ScoreMax) m_es++;
               m_last_player = 0; m_br = 1; m_phase = 3;
            end else if (nf && x < LeftLim) begin
               if (m_ps < ScoreMax) m_ps++;
               m_last_player = 1; m_br = 1; m_phase = 3;
            end
`ifdef MATCH_CTRL_PAUSE_EN
            else if (press) m_phase = 5;
`endif
         end
         3: begin
            if ((m_last_player ? m_ps : m_es) == WinScore) begin
               m_win = m_last_player; m_phase = 4;
            end else m_phase = 1;
         end
         4: if (press) m_phase = 0;
         5: if (press) m_phase = 2;
         default: m_phase = 0;
      endcase
      m_prev_key = key;
      m_armed = 1;
   endtask

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      expect_eq("model_state", 32'(state_o), 32'(m_phase));
      expect_eq("model_run", 32'(run_o), 32'(m_phase == 2));
      expect_eq("model_ball_reset", 32'(ball_reset_o), 32'(m_br));
      expect_eq("model_player", 32'(player_score_o), 32'(m_ps));
      expect_eq("model_enemy", 32'(enemy_score_o), 32'(m_es));
      if (m_phase == 4) expect_eq("model_winner", 32'(winner_o), 32'(m_win));
   endtask

   task automatic cycle(input logic k, input logic nf, input logic [9:0] x);
      start_key_i = k; new_frame_i = nf; ball_x_i = x;
      @(posedge clk_i);
      if (rst_ni) model_step(k, nf, int'(x)); else model_reset();
      #1;
      check_model();
   endtask

   task automatic expect_out(input string name, input int st, input int run, input int br,
                             input int ps, input int es);
      expect_eq({name, "_state"}, 32'(state_o), 32'(st));
      expect_eq({name, "_run"}, 32'(run_o), 32'(run));
      expect_eq({name, "_br"}, 32'(ball_reset_o), 32'(br));
      expect_eq({name, "_player"}, 32'(player_score_o), 32'(ps));
      expect_eq({name, "_enemy"}, 32'(enemy_score_o), 32'(es));
   endtask

   // Asynchronous reset mid-cycle, key held high across the release.
   task automatic pulse_reset();
      #2 rst_ni = 1'b0;
      start_key_i = 1'b1;
      model_reset();
      #1;
      expect_out("async_rst", 0, 0, 0, 0, 0);
      expect_eq("async_rst_winner", 32'(winner_o), 32'd0);
      @(posedge clk_i);
      #4 rst_ni = 1'b1;
   endtask

   typedef struct {
      logic       key;
      logic       nf;
      logic [9:0] x;
      int         rep;
      int         st;
      int         run;
      int         br;
      int         ps;
      int         es;
   } vec_t;

   vec_t tbl[18];

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 10'd300, 1,  0, 0, 0, 0, 0};
      tbl[1]  = '{1'b1, 1'b0, 10'd300, 1,  1, 0, 1, 0, 0};
      tbl[2]  = '{1'b1, 1'b0, 10'd300, 1,  1, 0, 0, 0, 0};
      tbl[3]  = '{1'b0, 1'b1, 10'd300, 59, 1, 0, 0, 0, 0};
      tbl[4]  = '{1'b0, 1'b1, 10'd300, 1,  2, 1, 0, 0, 0};
      tbl[5]  = '{1'b0, 1'b0, 10'd5,   1,  2, 1, 0, 0, 0};
      tbl[6]  = '{1'b0, 1'b1, 10'd5,   1,  3, 0, 1, 1, 0};
      tbl[7]  = '{1'b0, 1'b0, 10'd300, 1,  1, 0, 0, 1, 0};
      tbl[8]  = '{1'b1, 1'b1, 10'd300, 60, 2, 1, 0, 1, 0};
      tbl[9]  = '{1'b0, 1'b1, 10'd300, 1,  2, 1, 0, 1, 0};
      tbl[10] = '{1'b0, 1'b1, 10'd9,   1,  3, 0, 1, 2, 0};
      tbl[11] = '{1'b0, 1'b0, 10'd300, 1,  1, 0, 0, 2, 0};
      tbl[12] = '{1'b0, 1'b1, 10'd300, 60, 2, 1, 0, 2, 0};
      tbl[13] = '{1'b0, 1'b1, 10'd10,  1,  2, 1, 0, 2, 0};
      tbl[14] = '{1'b0, 1'b1, 10'd640, 1,  2, 1, 0, 2, 0};
      tbl[15] = '{1'b0, 1'b1, 10'd641, 1,  3, 0, 1, 2, 1};
      tbl[16] = '{1'b0, 1'b0, 10'd300, 1,  1, 0, 0, 2, 1};
      tbl[17] = '{1'b0, 1'b1, 10'd300, 60, 2, 1, 0, 2, 1};

      model_reset();
      start_key_i = 1'b1;
      #12;
      expect_out("in_reset", 0, 0, 0, 0, 0);
      expect_eq("in_reset_winner", 32'(winner_o), 32'd0);
      @(posedge clk_i);
      #4 rst_ni = 1'b1;
      cycle(1'b1, 1'b0, 10'd300);
      expect_out("held_key_1", 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b0, 10'd300);
      expect_out("held_key_2", 0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].rep; r++) cycle(tbl[i].key, tbl[i].nf, tbl[i].x);
         expect_out($sformatf("tbl%0d", i), tbl[i].st, tbl[i].run, tbl[i].br, tbl[i].ps,
                    tbl[i].es);
      end

      // Start press while playing.
      cycle(1'b1, 1'b0, 10'd300);
`ifdef MATCH_CTRL_PAUSE_EN
      expect_out("pause_enter", 5, 0, 0, 2, 1);
      cycle(1'b0, 1'b1, 10'd650);
      expect_out("pause_oob", 5, 0, 0, 2, 1);
      cycle(1'b1, 1'b0, 10'd300);
      expect_out("pause_exit", 2, 1, 0, 2, 1);
`else
      expect_out("play_press", 2, 1, 0, 2, 1);
`endif
      cycle(1'b0, 1'b0, 10'd300);
      // Scoring frame and press together: scoring wins.
      cycle(1'b1, 1'b1, 10'd650);
      expect_out("press_vs_score", 3, 0, 1, 2, 2);
      cycle(1'b0, 1'b0, 10'd300);
      expect_out("after_point", 1, 0, 0, 2, 2);

      for (int p = 0; p < 5; p++) begin
         repeat (ServeFrames) cycle(1'b0, 1'b1, 10'd300);
         cycle(1'b0, 1'b1, 10'd650);
         cycle(1'b0, 1'b0, 10'd300);
      end
      expect_out("enemy_wins", 4, 0, 0, 2, 7);
      expect_eq("enemy_wins_winner", 32'(winner_o), 32'd0);
      cycle(1'b0, 1'b1, 10'd650);
      expect_out("over_hold", 4, 0, 0, 2, 7);
      cycle(1'b1, 1'b0, 10'd300);
      expect_out("over_to_idle", 0, 0, 0, 2, 7);
      cycle(1'b0, 1'b0, 10'd300);
      cycle(1'b1, 1'b0, 10'd300);
      expect_out("restart", 1, 0, 1, 0, 0);

      for (int p = 0; p < 9; p++) begin
         repeat (ServeFrames) cycle(1'b0, 1'b1, 10'd300);
         cycle(1'b0, 1'b1, (p < 3) ? 10'd5 : 10'd650);
         cycle(1'b0, 1'b0, 10'd300);
      end
      repeat (ServeFrames) cycle(1'b0, 1'b1, 10'd300);
      expect_out("mid_play_6_3", 2, 1, 0, 3, 6);
      pulse_reset();
      cycle(1'b1, 1'b0, 10'd300);
      expect_out("post_rst_held", 0, 0, 0, 0, 0);

      for (int n = 0; n < 6000; n++) begin
         logic       k, nf;
         logic [9:0] rx;
         k = start_key_i;
         if ($urandom_range(0, 7) == 0) k = ~k;
         nf = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 2))
            0:       rx = 10'($urandom_range(0, 9));
            1:       rx = 10'($urandom_range(10, 640));
            default: rx = 10'($urandom_range(641, 1023));
         endcase
         cycle(k, nf, rx);
         if ($urandom_range(0, 799) == 0) pulse_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
